// File: rtl/dma_pkg.sv
// Shared DMA definitions: sequencer state encoding and channel sizing,
// reused by the request arbiter, the 8237 top and the address/count datapath.
package dma_pkg;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        S1,
        S2,
        S3,
        S4,
        RELEASE
    } dma_state_e;

    function automatic logic [NCH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        return NCH'(1) << ch;
    endfunction

endpackage

// File: rtl/dma_prio_enc.sv
// Combinational 4-way priority encoder; the search starts at ptr and wraps,
// so ptr=0 gives fixed priority with channel 0 highest.
module dma_prio_enc
    import dma_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] grant,
    output logic            valid
);

    logic [CH_W-1:0] idx;

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = ptr + CH_W'(i);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_req_arbiter.sv
// DREQ synchroniser, priority resolution, HRQ/HLDA hold handshake and the
// S1..S4 single-transfer sequencer for the 8237-class DMA engine.
module dma_req_arbiter
    import dma_pkg::*;
#(
    parameter int SYNC_FF = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NCH-1:0]  dreq,
    input  logic [NCH-1:0]  mask,
    input  logic            rot_pri,
    input  logic            hlda,
    input  logic            rdy,
    input  logic            tc,
    input  logic            eop_n,
    output logic            hrq,
    output logic [NCH-1:0]  dack,
    output logic            adstb,
    output logic            xfer_stb,
    output logic [CH_W-1:0] xfer_ch,
    output logic            done,
    output dma_state_e      dbg_state,
    output logic [CH_W-1:0] dbg_ptr
);

    logic [NCH-1:0]  sync_q [SYNC_FF];
    logic [NCH-1:0]  sync_d [SYNC_FF];
    logic [NCH-1:0]  req_qual;

    dma_state_e      state_q,    state_d;
    logic [CH_W-1:0] xfer_ch_q,  xfer_ch_d;
    logic [CH_W-1:0] ptr_q,      ptr_d;
    logic            eop_seen_q, eop_seen_d;

    logic [CH_W-1:0] grant;
    logic            grant_valid;
    logic [CH_W-1:0] search_ptr;

    always_comb begin
        sync_d[0] = dreq;
        for (int i = 1; i < SYNC_FF; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign req_qual   = sync_q[SYNC_FF-1] & ~mask;
    assign search_ptr = rot_pri ? ptr_q : '0;

    dma_prio_enc u_prio (
        .req   (req_qual),
        .ptr   (search_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    // Any loss of hlda during S1..S4 aborts straight to IDLE without touching ptr.
    always_comb begin
        state_d    = state_q;
        xfer_ch_d  = xfer_ch_q;
        ptr_d      = ptr_q;
        eop_seen_d = eop_seen_q;
        case (state_q)
            IDLE: begin
                eop_seen_d = 1'b0;
                if (grant_valid && !hlda) begin
                    xfer_ch_d = grant;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (hlda) state_d = S1;
            end
            S1: begin
                state_d = hlda ? S2 : IDLE;
            end
            S2: begin
                if (!hlda) begin
                    state_d = IDLE;
                end else if (!eop_n) begin
                    state_d    = S4;
                    eop_seen_d = 1'b1;
                end else begin
                    state_d = S3;
                end
            end
            S3: begin
                if (!hlda) begin
                    state_d = IDLE;
                end else if (!eop_n) begin
                    state_d    = S4;
                    eop_seen_d = 1'b1;
                end else if (rdy) begin
                    state_d = S4;
                end
            end
            S4: begin
                if (!hlda) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                    ptr_d   = xfer_ch_q + CH_W'(1);
                end
            end
            RELEASE: begin
                eop_seen_d = 1'b0;
                if (!hlda) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_FF; i++) begin
                sync_q[i] <= '0;
            end
            state_q    <= IDLE;
            xfer_ch_q  <= '0;
            ptr_q      <= '0;
            eop_seen_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_FF; i++) begin
                sync_q[i] <= sync_d[i];
            end
            state_q    <= state_d;
            xfer_ch_q  <= xfer_ch_d;
            ptr_q      <= ptr_d;
            eop_seen_q <= eop_seen_d;
        end
    end

    always_comb begin
        hrq      = (state_q == HOLD) || (state_q == S1) || (state_q == S2) ||
                   (state_q == S3)   || (state_q == S4);
        adstb    = (state_q == S1);
        dack     = ((state_q == S2) || (state_q == S3) || (state_q == S4)) ?
                   ch_onehot(xfer_ch_q) : '0;
        xfer_stb = (state_q == S4) && hlda;
        done     = xfer_stb && (tc || !eop_n || eop_seen_q);
    end

    assign xfer_ch   = xfer_ch_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed bench for dma_req_arbiter: an expected queue of {done, channel}
// per transfer, drained by a monitor on every xfer_stb.
module tb_dma_req_arbiter;
    import dma_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [3:0] dreq;
    logic [3:0] mask;
    logic       rot_pri;
    logic       hlda;
    logic       rdy;
    logic       tc;
    logic       eop_n;
    logic       hrq;
    logic [3:0] dack;
    logic       adstb;
    logic       xfer_stb;
    logic [1:0] xfer_ch;
    logic       done;
    dma_state_e dbg_state;
    logic [1:0] dbg_ptr;

    int tests_run = 0;
    int tests_failed = 0;
    int stb_seen = 0;
    bit hlda_auto = 0;

    logic [2:0] exp_q[$];

    int svc_adstb, svc_dack, svc_stb, svc_bad, svc_ch, svc_lat, svc_hrq_idx, svc_ch_at_hrq;
    bit svc_ok;

    dma_req_arbiter #(.SYNC_FF(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dreq      (dreq),
        .mask      (mask),
        .rot_pri   (rot_pri),
        .hlda      (hlda),
        .rdy       (rdy),
        .tc        (tc),
        .eop_n     (eop_n),
        .hrq       (hrq),
        .dack      (dack),
        .adstb     (adstb),
        .xfer_stb  (xfer_stb),
        .xfer_ch   (xfer_ch),
        .done      (done),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU model: hlda follows hrq one cycle later when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (hlda_auto) hlda = hrq;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Runs one service until the FSM is back in IDLE with hlda low.
    // drop: dreq bits cleared when hrq is first seen; waits: rdy=0 wait states in S3;
    // eop_s2: pull eop_n low in S2 (with rdy=0).
    task automatic run_service(input logic [3:0] drop, input int waits, input bit eop_s2);
        bit started;
        int hlda_idx, stb_idx, w;
        started = 0; hlda_idx = -1; stb_idx = -1; w = 0;
        svc_adstb = 0; svc_dack = 0; svc_stb = 0; svc_bad = 0; svc_ch = -1;
        svc_hrq_idx = -1; svc_ch_at_hrq = -1; svc_ok = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (hrq && !started) begin
                started = 1;
                svc_hrq_idx = c;
                svc_ch_at_hrq = int'(xfer_ch);
                dreq = dreq & ~drop;
            end
            if (adstb) svc_adstb++;
            if (dack != 4'b0000) begin
                svc_dack++;
                if (!$onehot(dack)) svc_bad++;
                svc_ch = oh_idx(dack);
            end
            if (xfer_stb) begin
                svc_stb++;
                stb_idx = c;
            end
            if (hlda && dbg_state == HOLD && hlda_idx < 0) hlda_idx = c;
            if (dbg_state == S2) begin
                if (waits > 0) rdy = 1'b0;
                if (eop_s2) begin
                    eop_n = 1'b0;
                    rdy   = 1'b0;
                end
            end
            if (dbg_state == S3) begin
                w++;
                if (w > waits) rdy = 1'b1;
            end
            if (dbg_state == S4) begin
                eop_n = 1'b1;
                rdy   = 1'b1;
            end
            if (started && dbg_state == IDLE && !hlda) begin
                svc_ok = 1;
                break;
            end
        end
        svc_lat = stb_idx - hlda_idx;
        check("service_completes", 32'(svc_ok), 32'd1);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (xfer_stb) begin
                stb_seen++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_xfer_stb: got ch %0d done %0b, expected none", xfer_ch, done);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_done_ch", 32'({done, xfer_ch}), 32'(e));
                end
            end else if (done) begin
                tests_run++;
                tests_failed++;
                $display("FAIL done_without_stb: got done=1, expected 0");
            end
        end
    end

    initial begin
        #200000;
        tests_failed++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int stb0, hrq_cnt;
        reset_n = 1'b0; dreq = '0; mask = '0; rot_pri = 1'b0; hlda = 1'b0;
        rdy = 1'b1; tc = 1'b0; eop_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({hrq, dack, adstb, xfer_stb, done, xfer_ch}), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        check("reset_ptr", 32'(dbg_ptr), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        hlda_auto = 1;

        // 1: single request on ch2, drops before hlda but the cycle still runs
        dreq = 4'b0100;
        exp_q.push_back({1'b0, 2'd2});
        run_service(4'b0100, 0, 0);
        check("t1_hrq_latency", 32'(svc_hrq_idx + 1), 32'd3);
        check("t1_xfer_ch_at_hrq", 32'(svc_ch_at_hrq), 32'd2);
        check("t1_adstb_cycles", 32'(svc_adstb), 32'd1);
        check("t1_dack_cycles", 32'(svc_dack), 32'd3);
        check("t1_dack_ch", 32'(svc_ch), 32'd2);
        check("t1_stb_count", 32'(svc_stb), 32'd1);
        check("t1_hlda_to_stb", 32'(svc_lat), 32'd4);
        check("t1_dack_onehot", 32'(svc_bad), 32'd0);

        // 2: fixed priority, ch1 wins twice, ch3 only after ch1 drops
        dreq = 4'b1010;
        exp_q.push_back({1'b0, 2'd1});
        exp_q.push_back({1'b0, 2'd1});
        exp_q.push_back({1'b0, 2'd3});
        run_service(4'b0000, 0, 0);
        check("t2_first_grant", 32'(svc_ch), 32'd1);
        run_service(4'b0010, 0, 0);
        check("t2_second_grant", 32'(svc_ch), 32'd1);
        run_service(4'b1000, 0, 0);
        check("t2_third_grant", 32'(svc_ch), 32'd3);

        // 3: rotating priority from a fresh pointer
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rot_pri = 1'b1;
        dreq = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 2'(k)});
        run_service(4'b0000, 0, 0);
        check("t3_grant0", 32'(svc_ch), 32'd0);
        check("t3_ptr_after_ch0", 32'(dbg_ptr), 32'd1);
        run_service(4'b0000, 0, 0);
        check("t3_grant1", 32'(svc_ch), 32'd1);
        run_service(4'b0000, 0, 0);
        check("t3_grant2", 32'(svc_ch), 32'd2);
        run_service(4'b1111, 0, 0);
        check("t3_grant3", 32'(svc_ch), 32'd3);
        check("t3_ptr_wraps", 32'(dbg_ptr), 32'd0);
        rot_pri = 1'b0;

        // 4: three wait states in S3 add three cycles to the 3-cycle dack baseline
        dreq = 4'b0001;
        exp_q.push_back({1'b0, 2'd0});
        run_service(4'b0001, 3, 0);
        check("t4_dack_cycles", 32'(svc_dack), 32'd6);
        check("t4_hlda_to_stb", 32'(svc_lat), 32'd7);
        check("t4_stb_count", 32'(svc_stb), 32'd1);

        // 5a: eop in S2 with rdy low jumps to S4, done fires
        dreq = 4'b0010;
        exp_q.push_back({1'b1, 2'd1});
        run_service(4'b0010, 0, 1);
        check("t5_eop_dack_cycles", 32'(svc_dack), 32'd2);
        check("t5_eop_hlda_to_stb", 32'(svc_lat), 32'd3);
        // 5b: tc in a normal S4
        tc = 1'b1;
        dreq = 4'b0100;
        exp_q.push_back({1'b1, 2'd2});
        run_service(4'b0100, 0, 0);
        tc = 1'b0;
        check("t5_ptr_after_ch2", 32'(dbg_ptr), 32'd3);

        // 6a: hlda dropped in S3 aborts
        dreq = 4'b0001;
        rdy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (dbg_state == S3) break;
        end
        check("t6_reached_s3", 32'(dbg_state), 32'(S3));
        stb0 = stb_seen;
        hlda_auto = 0;
        hlda = 1'b0;
        mask = 4'b1111;
        @(negedge clk);
        check("t6_abort_dack_hrq", 32'({hrq, dack}), 32'd0);
        check("t6_abort_state", 32'(dbg_state), 32'(IDLE));
        repeat (3) @(negedge clk);
        check("t6_abort_no_stb", 32'(stb_seen - stb0), 32'd0);
        check("t6_abort_ptr_kept", 32'(dbg_ptr), 32'd3);
        rdy = 1'b1;
        dreq = 4'b0000;
        repeat (3) @(negedge clk);
        mask = 4'b0000;
        hlda_auto = 1;

        // 6b: async reset in S2
        dreq = 4'b0010;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (dbg_state == S2) break;
        end
        check("t6_reached_s2", 32'(dbg_state), 32'(S2));
        stb0 = stb_seen;
        reset_n = 1'b0;
        #1;
        check("t6_reset_outputs", 32'({hrq, dack, adstb, xfer_stb, done, xfer_ch}), 32'd0);
        check("t6_reset_ptr", 32'(dbg_ptr), 32'd0);
        check("t6_reset_state", 32'(dbg_state), 32'(IDLE));
        mask = 4'b1111;
        dreq = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_reset_no_stb", 32'(stb_seen - stb0), 32'd0);
        mask = 4'b0000;

        // 7: masked request never raises hrq
        mask = 4'b0100;
        dreq = 4'b0100;
        hrq_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (hrq) hrq_cnt++;
        end
        check("t7_masked_hrq", 32'(hrq_cnt), 32'd0);
        dreq = 4'b0000;
        mask = 4'b0000;
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
